// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
//  Executes element-wise jobs handed over by model_manager. A job starts on the
//  rising edge of fpu_avail; op and the handles a,b,c,d are latched then. The
//  element count N is d.end - d.begin. Each element is read from memory, the
//  result is computed, and it is written back through a single-port SRAM.
//  PARAM_UPDATE uses an external FMA unit computing fma_a - fma_b*fma_c.
//  Unsupported ops finish at once with job_err=1.
//
//  Ports
//   clk, rst_l            clock, asynchronous active-low reset
//   fpu_op, fpu_avail     job opcode and request level
//   a, b, c, d            region handles {region_end, region_begin}, end exclusive
//   fpu_done, job_err     one-cycle completion pulse, error flag valid with it
//   mem_addr/re/we/wdata  SRAM request (read data returns one cycle after mem_re)
//   mem_rdata             SRAM read data
//   fma_req, fma_a/b/c    FMA request held until fma_ack
//   fma_ack, fma_res      FMA single-cycle result strobe and result
//
//  Configuration macro: FPU_DISPATCH_LEN_CHECK_EN
//   When defined, a job whose a-region (or, for RELU_BW, c-region) length
//   differs from N finishes at once with job_err=1 and no memory traffic.
// -----------------------------------------------------------------------------
package fpu_dispatch_pkg;
    localparam int ADDR_W = 32;

    typedef enum logic [3:0] {
        OP_NONE      = 4'd0,
        LINEAR_FW    = 4'd1,
        LINEAR_BW    = 4'd2,
        RELU_FW      = 4'd3,
        RELU_BW      = 4'd4,
        SOFTMAX_FW   = 4'd5,
        LOSS_BW      = 4'd6,
        PARAM_UPDATE = 4'd7
    } op_t;

    typedef struct packed {
        logic [ADDR_W-1:0] region_end;
        logic [ADDR_W-1:0] region_begin;
    } mem_handle_t;
endpackage

module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] LR     = 32'h3C23D70A
) (
    input  logic              clk,
    input  logic              rst_l,
    input  op_t               fpu_op,
    input  logic              fpu_avail,
    input  mem_handle_t       a,
    input  mem_handle_t       b,
    input  mem_handle_t       c,
    input  mem_handle_t       d,
    output logic              fpu_done,
    output logic              job_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fma_req,
    output logic [DATA_W-1:0] fma_a,
    output logic [DATA_W-1:0] fma_b,
    output logic [DATA_W-1:0] fma_c,
    input  logic              fma_ack,
    input  logic [DATA_W-1:0] fma_res
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_P = 3'd1,
        S_RD_S = 3'd2,
        S_CALC = 3'd3,
        S_FMA  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

    // Negative inputs (including -0.0) clamp to +0.
    function automatic logic [DATA_W-1:0] relu_fw_f(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ZERO_D : x;
    endfunction

    // Gradient passes only where the forward input was strictly positive;
    // both signed zeros block it.
    function automatic logic [DATA_W-1:0] relu_bw_f(input logic [DATA_W-1:0] g,
                                                    input logic [DATA_W-1:0] x);
        return (x[DATA_W-1] || (x[DATA_W-2:0] == {(DATA_W-1){1'b0}})) ? ZERO_D : g;
    endfunction

    state_t            state_q, state_d;
    logic              avail_q;
    op_t               op_q;
    logic [ADDR_W-1:0] a_begin_q, c_begin_q, d_begin_q, n_q;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;

    logic              fpu_done_q, fpu_done_d;
    logic              job_err_q, job_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              fma_req_q, fma_req_d;
    logic [DATA_W-1:0] fma_a_q, fma_a_d;
    logic [DATA_W-1:0] fma_b_q, fma_b_d;
    logic [DATA_W-1:0] fma_c_q, fma_c_d;

    logic              start_s;
    logic              op_ok_s;
    logic              len_bad_s;
    logic              last_s;
    logic [ADDR_W-1:0] n_s;
    logic [ADDR_W-1:0] s_base_s;
    logic              unused_s;

    assign start_s  = fpu_avail & ~avail_q;
    assign n_s      = d.region_end - d.region_begin;
    assign op_ok_s  = (fpu_op == RELU_FW) || (fpu_op == RELU_BW) || (fpu_op == PARAM_UPDATE);
    assign s_base_s = (op_q == RELU_BW) ? c_begin_q : d_begin_q;
    assign last_s   = (idx_q == (n_q - ONE_A));

`ifdef FPU_DISPATCH_LEN_CHECK_EN
    assign len_bad_s = ((a.region_end - a.region_begin) != n_s) ||
                       ((fpu_op == RELU_BW) && ((c.region_end - c.region_begin) != n_s));
`else
    assign len_bad_s = 1'b0;
`endif

    // b carries no information for the supported ops; the region ends of a and
    // c only matter when the length check is compiled in.
    assign unused_s = ^{b, a.region_end, c.region_end};

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        p_data_d    = p_data_q;
        fpu_done_d  = 1'b0;
        job_err_d   = job_err_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        fma_req_d   = 1'b0;
        fma_a_d     = fma_a_q;
        fma_b_d     = fma_b_q;
        fma_c_d     = fma_c_q;

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    idx_d = ZERO_A;
                    if (!op_ok_s || len_bad_s) begin
                        state_d    = S_DONE;
                        fpu_done_d = 1'b1;
                        job_err_d  = 1'b1;
                    end else if (n_s == ZERO_A) begin
                        state_d    = S_DONE;
                        fpu_done_d = 1'b1;
                        job_err_d  = 1'b0;
                    end else begin
                        state_d    = S_RD_P;
                        job_err_d  = 1'b0;
                        mem_re_d   = 1'b1;
                        mem_addr_d = a.region_begin;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_P: begin
                // RELU_FW has no secondary operand: primary data lands in CALC.
                if (op_q == RELU_FW) begin
                    state_d = S_CALC;
                end else begin
                    state_d    = S_RD_S;
                    mem_re_d   = 1'b1;
                    mem_addr_d = s_base_s + idx_q;
                end
            end
            S_RD_S: begin
                state_d  = S_CALC;
                p_data_d = mem_rdata;
            end
            S_CALC: begin
                case (op_q)
                    RELU_FW: begin
                        state_d     = S_WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = d_begin_q + idx_q;
                        mem_wdata_d = relu_fw_f(mem_rdata);
                    end
                    RELU_BW: begin
                        state_d     = S_WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = d_begin_q + idx_q;
                        mem_wdata_d = relu_bw_f(p_data_q, mem_rdata);
                    end
                    PARAM_UPDATE: begin
                        state_d   = S_FMA;
                        fma_req_d = 1'b1;
                        fma_a_d   = mem_rdata;
                        fma_b_d   = LR;
                        fma_c_d   = p_data_q;
                    end
                    default: begin
                        state_d    = S_DONE;
                        fpu_done_d = 1'b1;
                        job_err_d  = 1'b1;
                    end
                endcase
            end
            S_FMA: begin
                if (fma_ack) begin
                    state_d     = S_WR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = d_begin_q + idx_q;
                    mem_wdata_d = fma_res;
                end else begin
                    fma_req_d = 1'b1;
                end
            end
            S_WR: begin
                if (last_s) begin
                    state_d    = S_DONE;
                    fpu_done_d = 1'b1;
                    job_err_d  = 1'b0;
                end else begin
                    state_d    = S_RD_P;
                    idx_d      = idx_q + ONE_A;
                    mem_re_d   = 1'b1;
                    mem_addr_d = a_begin_q + idx_q + ONE_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, element index, request-edge detector and latched job parameters.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= S_IDLE;
            avail_q   <= 1'b0;
            idx_q     <= ZERO_A;
            p_data_q  <= ZERO_D;
            op_q      <= OP_NONE;
            a_begin_q <= ZERO_A;
            c_begin_q <= ZERO_A;
            d_begin_q <= ZERO_A;
            n_q       <= ZERO_A;
        end else begin
            state_q  <= state_d;
            avail_q  <= fpu_avail;
            idx_q    <= idx_d;
            p_data_q <= p_data_d;
            if ((state_q == S_IDLE) && start_s) begin
                op_q      <= fpu_op;
                a_begin_q <= a.region_begin;
                c_begin_q <= c.region_begin;
                d_begin_q <= d.region_begin;
                n_q       <= n_s;
            end
        end
    end

    // Output registers; strobes are high exactly while the matching state is held.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fpu_done_q  <= 1'b0;
            job_err_q   <= 1'b0;
            mem_addr_q  <= ZERO_A;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= ZERO_D;
            fma_req_q   <= 1'b0;
            fma_a_q     <= ZERO_D;
            fma_b_q     <= ZERO_D;
            fma_c_q     <= ZERO_D;
        end else begin
            fpu_done_q  <= fpu_done_d;
            job_err_q   <= job_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            fma_req_q   <= fma_req_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            fma_c_q     <= fma_c_d;
        end
    end

    assign fpu_done  = fpu_done_q;
    assign job_err   = job_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign fma_req   = fma_req_q;
    assign fma_a     = fma_a_q;
    assign fma_b     = fma_b_q;
    assign fma_c     = fma_c_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fpu_dispatch
//  Table of jobs with expected results, plus hand-written sequences for
//  PARAM_UPDATE with a slow FMA, a long-held request level and a mid-job reset.
//  Expected writes are queued when a job is issued and compared as the DUT
//  issues mem_we. Includes a behavioural SRAM and FMA responder.
// -----------------------------------------------------------------------------
module tb_fpu_dispatch;
    import fpu_dispatch_pkg::*;

    localparam logic [31:0] LR      = 32'h3C23D70A;
    localparam logic [31:0] FMA_RES = 32'h409F5C29;
    localparam int          FMA_LAT = 7;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    op_t         fpu_op = OP_NONE;
    logic        fpu_avail = 1'b0;
    mem_handle_t a = '0, b = '0, c = '0, d = '0;
    logic        fpu_done, job_err, mem_re, mem_we, fma_req;
    logic [31:0] mem_addr, mem_wdata, fma_a, fma_b, fma_c;
    logic [31:0] mem_rdata = 32'h0;
    logic        fma_ack = 1'b0;
    logic [31:0] fma_res;
    int          fma_cyc = 0;

    assign fma_res = FMA_RES;

    always #5 clk = ~clk;

    fpu_dispatch dut (
        .clk(clk), .rst_l(rst_l), .fpu_op(fpu_op), .fpu_avail(fpu_avail),
        .a(a), .b(b), .c(c), .d(d),
        .fpu_done(fpu_done), .job_err(job_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fma_req(fma_req), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_ack(fma_ack), .fma_res(fma_res)
    );

    // SRAM contents: 1.0,-2.0,0.0,-0.0 | dLdz 2.0,3.0 | 3.0,2.0 | x -1.0,0.5 | +0,-0 ...
    logic [31:0] mem [0:63] = '{
        0: 32'h3F800000, 1: 32'hC0000000, 2: 32'h00000000, 3: 32'h80000000,
        4: 32'h40000000, 5: 32'h40400000, 6: 32'h40400000, 7: 32'h40000000,
        8: 32'hBF800000, 9: 32'h3F000000, 10: 32'h00000000, 11: 32'h80000000,
        12: 32'h3F800000, 30: 32'h40A00000,
        40: 32'h3F800000, 41: 32'hBF800000, 42: 32'h40000000, 43: 32'hC0400000,
        48: 32'hC0800000, 49: 32'h40E00000, 50: 32'h3F800000, 51: 32'h00000001,
        63: 32'hBF800000,
        default: 32'h0
    };

    // Behavioural SRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[5:0]];
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    end

    // FMA responder: acks in the FMA_LAT-th cycle of a held request.
    always @(posedge clk) begin
        if (fma_req && !fma_ack) begin
            fma_cyc <= fma_cyc + 1;
            fma_ack <= (fma_cyc == FMA_LAT - 2);
        end else begin
            fma_cyc <= 0;
            fma_ack <= 1'b0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_re = 0, n_we = 0, n_done = 0, n_fma = 0;
    logic [31:0] fa_seen = 32'h0, fb_seen = 32'h0, fc_seen = 32'h0;

    // Output monitor: traffic counters and scoreboard pop on every write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_re) n_re++;
        if (mem_we) n_we++;
        if (fpu_done) n_done++;
        if (fma_req) begin
            n_fma++;
            fa_seen = fma_a;
            fb_seen = fma_b;
            fc_seen = fma_c;
        end
        if (mem_re || mem_we) check("strobe_excl", {63'b0, mem_re & mem_we}, 64'd0);
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'b0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {32'b0, mem_addr}, {32'b0, e.addr});
                check("wr_data", {32'b0, mem_wdata}, {32'b0, e.data});
            end
        end
    end

    typedef struct {
        string             nm;
        op_t               op;
        logic [31:0]       ab, ae, cb, ce, db, de;
        logic              err;
        int                nw;
        logic [3:0][31:0]  w;
        int                cyc;
    } vec_t;

    function automatic vec_t mk(input string nm, input op_t op,
                                input logic [31:0] ab, ae, cb, ce, db, de,
                                input logic err, input int nw,
                                input logic [31:0] w0, w1, w2, w3, input int cyc);
        vec_t v;
        v.nm = nm; v.op = op; v.ab = ab; v.ae = ae; v.cb = cb; v.ce = ce;
        v.db = db; v.de = de; v.err = err; v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.cyc = cyc;
        return v;
    endfunction

    // Issue one job, wait for fpu_done and compare latency, error and traffic.
    task automatic run_job(input vec_t v);
        int cnt, rd0, wr0;
        logic got;
        @(negedge clk);
        fpu_op = v.op;
        a = '{region_end: v.ae, region_begin: v.ab};
        b = '{region_end: 32'd5, region_begin: 32'd3};
        c = '{region_end: v.ce, region_begin: v.cb};
        d = '{region_end: v.de, region_begin: v.db};
        for (int i = 0; i < v.nw; i++) exp_q.push_back('{addr: v.db + i, data: v.w[i]});
        rd0 = n_re;
        wr0 = n_we;
        fpu_avail = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (cnt < 300 && !got) begin
            @(posedge clk);
            #1;
            cnt++;
            if (fpu_done) got = 1'b1;
        end
        check({v.nm, "_done"}, {63'b0, got}, 64'd1);
        check({v.nm, "_latency"}, cnt, v.cyc);
        check({v.nm, "_job_err"}, {63'b0, job_err}, {63'b0, v.err});
        @(negedge clk);
        fpu_avail = 1'b0;
        repeat (2) @(negedge clk);
        check({v.nm, "_writes"}, n_we - wr0, v.nw);
        if (v.nw == 0) check({v.nm, "_reads"}, n_re - rd0, 0);
        check({v.nm, "_sb_left"}, exp_q.size(), 0);
    endtask

    vec_t vt [8];

    initial begin
        int d0, f0, wr0, k;
        vt[0] = mk("relu_fw", RELU_FW, 0, 4, 0, 0, 16, 20, 1'b0, 4,
                   32'h3F800000, 32'h0, 32'h0, 32'h0, 13);
        vt[1] = mk("relu_bw", RELU_BW, 4, 6, 8, 10, 20, 22, 1'b0, 2,
                   32'h0, 32'h40400000, 32'h0, 32'h0, 9);
        vt[2] = mk("relu_bw_zero", RELU_BW, 6, 8, 10, 12, 24, 26, 1'b0, 2,
                   32'h0, 32'h0, 32'h0, 32'h0, 9);
        vt[3] = mk("n_zero", RELU_FW, 8, 8, 0, 0, 8, 8, 1'b0, 0,
                   32'h0, 32'h0, 32'h0, 32'h0, 1);
        vt[4] = mk("bad_op", LINEAR_FW, 0, 4, 0, 0, 16, 20, 1'b1, 0,
                   32'h0, 32'h0, 32'h0, 32'h0, 1);
        vt[5] = mk("addr_wrap", RELU_FW, 32'hFFFF_FFFF, 1, 0, 0, 28, 30, 1'b0, 2,
                   32'h0, 32'h3F800000, 32'h0, 32'h0, 7);
`ifdef FPU_DISPATCH_LEN_CHECK_EN
        vt[6] = mk("len_check", RELU_FW, 40, 43, 0, 0, 44, 48, 1'b1, 0,
                   32'h0, 32'h0, 32'h0, 32'h0, 1);
`else
        vt[6] = mk("len_check", RELU_FW, 40, 43, 0, 0, 44, 48, 1'b0, 4,
                   32'h3F800000, 32'h0, 32'h40000000, 32'h0, 13);
`endif
        vt[7] = mk("relu_bw_pass", RELU_BW, 48, 50, 50, 52, 52, 54, 1'b0, 2,
                   32'hC0800000, 32'h40E00000, 32'h0, 32'h0, 9);

        // Reset state.
        #2 rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {59'b0, fpu_done, job_err, mem_re, mem_we, fma_req}, 64'd0);
        check("rst_mem_addr", {32'b0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
        check("rst_fma_ops", {fma_a ^ fma_b, fma_c}, 64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(vt[i]);

        // PARAM_UPDATE with a seven-cycle FMA.
        f0 = n_fma;
        run_job(mk("param_upd", PARAM_UPDATE, 12, 13, 0, 0, 30, 31, 1'b0, 1,
                   FMA_RES, 32'h0, 32'h0, 32'h0, 4 + FMA_LAT + 1));
        check("fma_req_cycles", n_fma - f0, FMA_LAT);
        check("fma_a", {32'b0, fa_seen}, {32'b0, 32'h40A00000});
        check("fma_b", {32'b0, fb_seen}, {32'b0, LR});
        check("fma_c", {32'b0, fc_seen}, {32'b0, 32'h3F800000});

        // Request level held long after completion: exactly one pulse.
        @(negedge clk);
        fpu_op = RELU_FW;
        a = '{region_end: 32'd2, region_begin: 32'd1};
        d = '{region_end: 32'd33, region_begin: 32'd32};
        exp_q.push_back('{addr: 32'd32, data: 32'h0});
        d0 = n_done;
        fpu_avail = 1'b1;
        repeat (4 + 50) @(negedge clk);
        check("hold_one_done", n_done - d0, 1);
        fpu_avail = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_sb_left", exp_q.size(), 0);

        // Asynchronous reset at element 2 of a RELU_FW job.
        fpu_op = RELU_FW;
        a = '{region_end: 32'd4, region_begin: 32'd0};
        d = '{region_end: 32'd40, region_begin: 32'd36};
        exp_q.push_back('{addr: 32'd36, data: 32'h3F800000});
        exp_q.push_back('{addr: 32'd37, data: 32'h0});
        wr0 = n_we;
        fpu_avail = 1'b1;
        k = 0;
        while ((n_we - wr0) < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_wait", {63'b0, (n_we - wr0) == 2}, 64'd1);
        @(posedge clk);
        #2 rst_l = 1'b0;
        fpu_avail = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_strobes", {59'b0, fpu_done, job_err, mem_re, mem_we, fma_req}, 64'd0);
        check("midrst_mem_addr", {32'b0, mem_addr}, 64'd0);
        check("midrst_sb_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        run_job(mk("restart", RELU_FW, 0, 4, 0, 0, 36, 40, 1'b0, 4,
                   32'h3F800000, 32'h0, 32'h0, 32'h0, 13));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
